// File: rtl/sanity_instr_mem.sv
// sanity_instr_mem
//   Single-port instruction memory with a core-style req/gnt/rvalid fetch
//   interface, a programmable grant delay and a side-band preload port.
//   One fetch may be outstanding; with WAIT_CYCLES=0 a new grant may issue
//   in the same cycle as the previous response, giving one fetch per cycle.
//
// Ports
//   clk_i, rst_ni        clock, async active-low reset
//   instr_req_i          fetch request
//   instr_addr_i[31:0]   byte fetch address (bits [1:0] ignored)
//   instr_gnt_o          request accepted this cycle (combinational)
//   instr_rvalid_o       response valid, one cycle after each grant
//   instr_rdata_o[31:0]  fetched word, held between responses
//   instr_err_o          out-of-range response, qualified by rvalid
//   load_en_i            preload write strobe
//   load_addr_i          preload word index
//   load_data_i[31:0]    preload word
//   fetch_count_o[31:0]  granted fetches, saturating
module sanity_instr_mem #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES  = 0,
  parameter logic [31:0] ILLEGAL_WORD = 32'h0000_0000
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           instr_req_i,
  input  logic [31:0]                    instr_addr_i,
  output logic                           instr_gnt_o,
  output logic                           instr_rvalid_o,
  output logic [31:0]                    instr_rdata_o,
  output logic                           instr_err_o,
  input  logic                           load_en_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr_i,
  input  logic [31:0]                    load_data_i,
  output logic [31:0]                    fetch_count_o
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_L = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_STALL, S_RESP} state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_wait;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_cnt;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic [31:0]   w_word;
  logic [AW-1:0] w_idx;
  logic          w_oor;
  logic          w_gnt;

  // Word offset from the base; an address below the base wraps to a huge
  // value but is flagged separately so the range check never depends on it.
  assign w_word = (instr_addr_i - BASE_ADDR) >> 2;
  assign w_idx  = w_word[AW-1:0];
  assign w_oor  = (instr_addr_i < BASE_ADDR) || (w_word >= 32'(DEPTH_WORDS));

  // The grant ignores the response state: the previous response always
  // completes in the grant's own cycle, so a grant in RESP is safe.
  assign w_gnt = instr_req_i && rst_ni && (r_wait == WAIT_L);

  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE, S_STALL, S_RESP: begin
        if (w_gnt)            w_state_nxt = S_RESP;
        else if (instr_req_i) w_state_nxt = S_STALL;
        else                  w_state_nxt = S_IDLE;
      end
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Counter restarts whenever the request drops, so a withdrawn request
      // earns no credit toward the next one.
      if (w_gnt || !instr_req_i) r_wait <= '0;
      else                       r_wait <= r_wait + 4'd1;
      if (w_gnt) begin
        // Array read sees pre-edge contents, so a same-cycle preload of this
        // word is not visible to this fetch.
        r_rdata <= w_oor ? ILLEGAL_WORD : r_mem[w_idx];
        r_err   <= w_oor;
        if (r_cnt != 32'hFFFF_FFFF) r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  // Storage is deliberately outside the reset domain so preloads survive.
  always_ff @(posedge clk_i) begin
    if (load_en_i) r_mem[load_addr_i] <= load_data_i;
  end

  assign instr_gnt_o    = w_gnt;
  assign instr_rvalid_o = (r_state == S_RESP);
  assign instr_rdata_o  = r_rdata;
  assign instr_err_o    = r_err;
  assign fetch_count_o  = r_cnt;

endmodule

// File: tb/tb_sanity_instr_mem.sv
module tb_sanity_instr_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req3 = 1'b0, req2 = 1'b0;
  logic [31:0] addr = '0;
  logic        ld_en = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;

  logic        g0, v0, e0, g3, v3, e3, g2, v2, e2;
  logic [31:0] d0, c0, d3, c3, d2, c2;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mm [1024];

  always #5 clk = ~clk;

  sanity_instr_mem #(.WAIT_CYCLES(0)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req0), .instr_addr_i(addr),
    .instr_gnt_o(g0), .instr_rvalid_o(v0), .instr_rdata_o(d0), .instr_err_o(e0),
    .load_en_i(ld_en), .load_addr_i(ld_addr), .load_data_i(ld_data), .fetch_count_o(c0));

  sanity_instr_mem #(.WAIT_CYCLES(3)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req3), .instr_addr_i(addr),
    .instr_gnt_o(g3), .instr_rvalid_o(v3), .instr_rdata_o(d3), .instr_err_o(e3),
    .load_en_i(ld_en), .load_addr_i(ld_addr), .load_data_i(ld_data), .fetch_count_o(c3));

  sanity_instr_mem #(.WAIT_CYCLES(2), .BASE_ADDR(32'h0000_0100),
                     .ILLEGAL_WORD(32'hBAD0_0BAD)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req2), .instr_addr_i(addr),
    .instr_gnt_o(g2), .instr_rvalid_o(v2), .instr_rdata_o(d2), .instr_err_o(e2),
    .load_en_i(ld_en), .load_addr_i(ld_addr), .load_data_i(ld_data), .fetch_count_o(c2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  typedef struct {
    logic        req;
    logic [31:0] a;
    logic        g;
    logic        v;
    logic [31:0] d;
    logic        e;
    logic [31:0] c;
  } vec_t;

  vec_t tbl [10];

  // reference model state for the randomized phase (u2: WAIT=2, base 0x100)
  int          m_run;
  logic        m_pv;
  logic [31:0] m_hd;
  logic        m_he;
  logic [31:0] m_cnt;
  logic        m_eg;
  logic        m_oor;
  logic [31:0] m_off;

  initial begin
    // ---------------- reset state, request held high ----------------
    req0 = 1'b1; req3 = 1'b1; req2 = 1'b1; addr = 32'h80;
    smp();
    chk1("rst.gnt0", g0, 1'b0);
    chk1("rst.gnt3", g3, 1'b0);
    chk1("rst.gnt2", g2, 1'b0);
    chk1("rst.rvalid0", v0, 1'b0);
    chk1("rst.err0", e0, 1'b0);
    chk ("rst.rdata0", d0, 32'h0);
    chk ("rst.count0", c0, 32'h0);
    tick();
    rst_n = 1'b1; req0 = 1'b0; req3 = 1'b0; req2 = 1'b0;

    // ---------------- preload the whole array ----------------
    for (int k = 0; k < 1024; k++) begin
      ld_en   = 1'b1;
      ld_addr = 10'(k);
      if (k == 32)      ld_data = 32'h0000_0093;
      else if (k == 33) ld_data = 32'h0010_0113;
      else              ld_data = {16'hC0DE, 16'(k)};
      mm[k] = ld_data;
      tick();
    end
    ld_en = 1'b0;

    // ---------------- table: WAIT=0 back-to-back and range edges ----------------
    tbl[0] = '{1'b1, 32'h0000_0080, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'd0};
    tbl[1] = '{1'b1, 32'h0000_0084, 1'b1, 1'b1, 32'h0000_0093, 1'b0, 32'd1};
    tbl[2] = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'h0010_0113, 1'b0, 32'd2};
    tbl[3] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0010_0113, 1'b0, 32'd2};
    tbl[4] = '{1'b1, 32'h0000_1000, 1'b1, 1'b0, 32'h0010_0113, 1'b0, 32'd2};
    tbl[5] = '{1'b1, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'd3};
    tbl[6] = '{1'b1, 32'h0000_0FFC, 1'b1, 1'b1, 32'hC0DE_0000, 1'b0, 32'd4};
    tbl[7] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'hC0DE_03FF, 1'b0, 32'd5};
    tbl[8] = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'd6};
    tbl[9] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'd6};
    for (int i = 0; i < 10; i++) begin
      req0 = tbl[i].req;
      addr = tbl[i].a;
      smp();
      chk1($sformatf("tbl%0d.gnt", i),    g0, tbl[i].g);
      chk1($sformatf("tbl%0d.rvalid", i), v0, tbl[i].v);
      chk ($sformatf("tbl%0d.rdata", i),  d0, tbl[i].d);
      chk1($sformatf("tbl%0d.err", i),    e0, tbl[i].e);
      chk ($sformatf("tbl%0d.count", i),  c0, tbl[i].c);
      tick();
    end

    // ---------------- WAIT=3: grant on 4th cycle of request ----------------
    req3 = 1'b1; addr = 32'h80;
    for (int i = 1; i <= 4; i++) begin
      smp();
      chk1($sformatf("w3.cyc%0d.gnt", i), g3, (i == 4));
      chk1($sformatf("w3.cyc%0d.rvalid", i), v3, 1'b0);
      tick();
    end
    req3 = 1'b0;
    smp();
    chk1("w3.rvalid", v3, 1'b1);
    chk ("w3.rdata", d3, 32'h0000_0093);
    chk1("w3.err", e3, 1'b0);
    chk ("w3.count", c3, 32'd1);
    tick();
    smp();
    chk1("w3.rvalid_off", v3, 1'b0);
    tick();

    // ---------------- preload in the grant cycle: read-before-write ----------------
    req0 = 1'b1; addr = 32'h80;
    ld_en = 1'b1; ld_addr = 10'd32; ld_data = 32'hDEAD_BEEF;
    smp();
    chk1("rbw.gnt", g0, 1'b1);
    tick();
    ld_en = 1'b0; mm[32] = 32'hDEAD_BEEF;
    smp();
    chk1("rbw.gnt2", g0, 1'b1);
    chk1("rbw.rvalid", v0, 1'b1);
    chk ("rbw.old", d0, 32'h0000_0093);
    tick();
    req0 = 1'b0;
    smp();
    chk1("rbw.rvalid2", v0, 1'b1);
    chk ("rbw.new", d0, 32'hDEAD_BEEF);
    chk ("rbw.count", c0, 32'd8);
    tick();

    // ---------------- reset with a response pending ----------------
    req0 = 1'b1; addr = 32'h84;
    smp();
    chk1("rstp.gnt", g0, 1'b1);
    rst_n = 1'b0; req0 = 1'b0;
    tick();
    smp();
    chk1("rstp.rvalid", v0, 1'b0);
    chk ("rstp.count", c0, 32'd0);
    chk ("rstp.rdata", d0, 32'd0);
    tick();
    rst_n = 1'b1;
    smp();
    chk1("rstp.rvalid_after", v0, 1'b0);
    tick();
    req0 = 1'b1; addr = 32'h80;
    smp();
    chk1("rstp.gnt80", g0, 1'b1);
    tick();
    addr = 32'h84;
    smp();
    chk1("rstp.rvalid80", v0, 1'b1);
    chk ("rstp.data80", d0, 32'hDEAD_BEEF);
    tick();
    req0 = 1'b0;
    smp();
    chk ("rstp.data84", d0, 32'h0010_0113);
    chk ("rstp.count2", c0, 32'd2);
    tick();

    // ---------------- WAIT=2: withdrawn request restarts the delay ----------------
    req2 = 1'b1; addr = 32'h80;
    smp(); chk1("w2.first", g2, 1'b0); tick();
    req2 = 1'b0;
    smp(); chk1("w2.drop", g2, 1'b0); tick();
    req2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk1($sformatf("w2.re%0d.gnt", i), g2, (i == 2));
      tick();
    end
    req2 = 1'b0;
    smp();
    chk1("w2.rvalid", v2, 1'b1);
    chk1("w2.err_below_base", e2, 1'b1);
    chk ("w2.illegal", d2, 32'hBAD0_0BAD);
    tick();

    // ---------------- randomized run against the model (u2) ----------------
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_run = 0; m_pv = 1'b0; m_hd = '0; m_he = 1'b0; m_cnt = '0;
    for (int n = 0; n < 400; n++) begin
      req2    = ($urandom_range(0, 3) != 0);
      addr    = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 32'h1200));
      ld_en   = ($urandom_range(0, 3) == 0);
      ld_addr = 10'($urandom_range(0, 1023));
      ld_data = $urandom;
      smp();
      // a request is granted once it has been pending (since it rose or
      // since the last grant) for exactly WAIT_CYCLES cycles
      m_eg = req2 && (m_run == 2);
      chk1($sformatf("rnd%0d.gnt", n),    g2, m_eg);
      chk1($sformatf("rnd%0d.rvalid", n), v2, m_pv);
      chk ($sformatf("rnd%0d.rdata", n),  d2, m_hd);
      chk1($sformatf("rnd%0d.err", n),    e2, m_he);
      chk ($sformatf("rnd%0d.count", n),  c2, m_cnt);
      if (m_eg) begin
        m_off = (addr - 32'h100) / 4;
        m_oor = (addr < 32'h100) || (m_off >= 1024);
        m_hd  = m_oor ? 32'hBAD0_0BAD : mm[m_off[9:0]];
        m_he  = m_oor;
        m_cnt = m_cnt + 1;
        m_pv  = 1'b1;
        m_run = 0;
      end else begin
        m_pv  = 1'b0;
        m_run = req2 ? m_run + 1 : 0;
      end
      if (ld_en) mm[ld_addr] = ld_data;
      tick();
    end
    req2 = 1'b0; ld_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sanity_instr_mem.md
SANITY_INSTR_MEM -- requirements
Module: sanity_instr_mem

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored (power of two, >=2).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 SHALL have parameter WAIT_CYCLES, default 0, stall cycles inserted before each grant (0..15).
REQ-004 SHALL have parameter ILLEGAL_WORD, default 32'h0000_0000, data returned for out-of-range fetches.
REQ-005 SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clk_i  input  1  clock, all state updates on rising edge.
REQ-007 rst_ni  input  1  asynchronous active-low reset.
REQ-008 instr_req_i  input  1  core fetch request.
REQ-009 instr_addr_i  input  32  byte fetch address.
REQ-010 instr_gnt_o  output  1  request accepted this cycle.
REQ-011 instr_rvalid_o  output  1  instr_rdata_o valid this cycle.
REQ-012 instr_rdata_o  output  32  fetched instruction word.
REQ-013 instr_err_o  output  1  out-of-range response, qualified by instr_rvalid_o.
REQ-014 load_en_i  input  1  preload write strobe.
REQ-015 load_addr_i  input  $clog2(DEPTH_WORDS)  preload word index.
REQ-016 load_data_i  input  32  preload word.
REQ-017 fetch_count_o  output  32  number of granted fetches, saturating.

Function
REQ-018 Word index SHALL be (instr_addr_i - BASE_ADDR) >> 2; addr bits [1:0] ignored.
REQ-019 Fetch SHALL be out-of-range if instr_addr_i < BASE_ADDR or index >= DEPTH_WORDS.
REQ-020 States SHALL be IDLE (no response pending), STALL (req seen, counting), RESP (rvalid driven this cycle).
REQ-021 instr_gnt_o SHALL be combinational: instr_req_i && rst_ni && wait counter == WAIT_CYCLES.
REQ-022 Wait counter SHALL increment each cycle instr_req_i is high without grant; clear on grant or when instr_req_i falls.
REQ-023 WAIT_CYCLES=0: grant in the same cycle req rises; WAIT_CYCLES=N: grant N cycles after req first seen.
REQ-024 instr_rvalid_o SHALL pulse exactly one cycle after each grant, for exactly one cycle.
REQ-025 instr_rdata_o SHALL hold mem[index] as captured at grant edge; ILLEGAL_WORD and instr_err_o=1 if out-of-range.
REQ-026 instr_rdata_o and instr_err_o SHALL hold last value while instr_rvalid_o=0.
REQ-027 Back-to-back: a new grant SHALL be allowed in the same cycle as instr_rvalid_o (RESP->RESP), giving one fetch per cycle when WAIT_CYCLES=0.
REQ-028 At most one outstanding request; grant SHALL not occur in a cycle where a previous grant's rvalid is still due next cycle except per REQ-027.
REQ-029 load_en_i SHALL write load_data_i to mem[load_addr_i] on rising edge; independent of fetch state.
REQ-030 Load and fetch to same word in same cycle: fetch SHALL return old data (read-before-write).
REQ-031 fetch_count_o SHALL increment by 1 per grant, saturate at 32'hFFFF_FFFF.

Reset
REQ-032 During reset instr_gnt_o, instr_rvalid_o, instr_err_o SHALL be 0; instr_rdata_o 32'h0; fetch_count_o 0; state IDLE; wait counter 0.
REQ-033 Reset asserted with a response pending SHALL drop that response; no rvalid after release.
REQ-034 Memory contents SHALL NOT be reset; preloaded words survive rst_ni pulses.

Verification
REQ-035 Preload mem[32]=32'h0000_0093, mem[33]=32'h0010_0113; WAIT_CYCLES=0, req held, addr 0x80 then 0x84 -> gnt both cycles, rvalid next cycles with 0x00000093, 0x00100113, err=0, fetch_count_o=2.
REQ-036 WAIT_CYCLES=3, req at addr 0x80 -> gnt on 4th cycle of req, rvalid one cycle later, data 0x00000093.
REQ-037 Fetch addr 0x0000_1000 (DEPTH_WORDS=1024) -> rvalid with rdata=ILLEGAL_WORD, instr_err_o=1.
REQ-038 load_en_i to index 32 with 0xDEADBEEF in grant cycle of addr 0x80 -> rvalid returns 0x00000093; next fetch returns 0xDEADBEEF.
REQ-039 rst_ni low in cycle after grant -> instr_rvalid_o stays 0, fetch_count_o=0; after release, fetch of 0x80 returns preloaded word unchanged.
REQ-040 WAIT_CYCLES=2, req drops after 1 cycle then reasserts -> counter restarts; gnt 2 cycles after reassertion.
